// File: rtl/dp_input_conditioner.sv
// Board input conditioner for the DP datapath: synchronises and
// debounces the switch bus and the push button, plus press/release pulses.
module dp_input_conditioner #(
   parameter int SW_WIDTH        = 18,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [SW_WIDTH-1:0] sw_raw,
   input  logic                but_raw,
   output logic [SW_WIDTH-1:0] sw_out,
   output logic                but_out,
   output logic                but_press,
   output logic                but_release,
   output logic [7:0]          press_count
);

   typedef enum logic [1:0] {
      B_UP   = 2'd0,
      B_FALL = 2'd1,
      B_DOWN = 2'd2,
      B_RISE = 2'd3
   } b_state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST =
      CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [SW_WIDTH-1:0]  sw_sync1;
   logic [SW_WIDTH-1:0]  sw_sync2;
   logic [SW_WIDTH-1:0]  sw_prev;
   logic [CNT_WIDTH-1:0] sw_cnt;

   logic                 b_sync1;
   logic                 b_sync2;
   logic [CNT_WIDTH-1:0] b_cnt;
   b_state_t             state;

   // Button synchroniser idles high so reset never looks like a press.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_sync1 <= '0;
         sw_sync2 <= '0;
         b_sync1  <= 1'b1;
         b_sync2  <= 1'b1;
      end else begin
         sw_sync1 <= sw_raw;
         sw_sync2 <= sw_sync1;
         b_sync1  <= but_raw;
         b_sync2  <= b_sync1;
      end
   end

   // One window for the whole bus: any bit moving restarts it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sw_prev <= '0;
         sw_cnt  <= '0;
         sw_out  <= '0;
      end else begin
         sw_prev <= sw_sync2;
         if (sw_sync2 != sw_prev) begin
            sw_cnt <= '0;
         end else if (sw_sync2 != sw_out) begin
            if (sw_cnt == CNT_LAST) begin
               sw_out <= sw_sync2;
               sw_cnt <= '0;
            end else begin
               sw_cnt <= sw_cnt + 1'b1;
            end
         end else begin
            sw_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= B_UP;
         b_cnt       <= '0;
         but_out     <= 1'b1;
         but_press   <= 1'b0;
         but_release <= 1'b0;
         press_count <= 8'd0;
      end else begin
         but_press   <= 1'b0;
         but_release <= 1'b0;
         case (state)
            B_UP: begin
               if (!b_sync2) begin
                  state <= B_FALL;
                  b_cnt <= '0;
               end
            end
            B_FALL: begin
               if (b_sync2) begin
                  state <= B_UP;
               end else if (b_cnt == CNT_LAST) begin
                  state       <= B_DOWN;
                  but_out     <= 1'b0;
                  but_press   <= 1'b1;
                  press_count <= press_count + 8'd1;
               end else begin
                  b_cnt <= b_cnt + 1'b1;
               end
            end
            B_DOWN: begin
               if (b_sync2) begin
                  state <= B_RISE;
                  b_cnt <= '0;
               end
            end
            B_RISE: begin
               if (!b_sync2) begin
                  state <= B_DOWN;
               end else if (b_cnt == CNT_LAST) begin
                  state       <= B_UP;
                  but_out     <= 1'b1;
                  but_release <= 1'b1;
               end else begin
                  b_cnt <= b_cnt + 1'b1;
               end
            end
            default: begin
               state   <= B_UP;
               b_cnt   <= '0;
               but_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dp_input_conditioner.sv
// Directed bench for dp_input_conditioner with DEBOUNCE_CYCLES=4.
// Latency counted from the edge right after an input is driven.
module tb_dp_input_conditioner;

   localparam int SW_W = 18;

   logic            clock;
   logic            reset_n;
   logic [SW_W-1:0] sw_raw;
   logic            but_raw;
   logic [SW_W-1:0] sw_out;
   logic            but_out;
   logic            but_press;
   logic            but_release;
   logic [7:0]      press_count;

   int n_cmp;
   int n_bad;

   dp_input_conditioner #(
      .SW_WIDTH       (SW_W),
      .DEBOUNCE_CYCLES(4),
      .CNT_WIDTH      (3)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .sw_raw     (sw_raw),
      .but_raw    (but_raw),
      .sw_out     (sw_out),
      .but_out    (but_out),
      .but_press  (but_press),
      .but_release(but_release),
      .press_count(press_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      sw_raw  = '0;
      but_raw = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (sw_out !== 18'h0) begin
         n_bad++;
         $display("FAIL reset_sw got %h want 0", sw_out);
      end
      n_cmp++;
      if (but_out !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_but got %b want 1", but_out);
      end
      n_cmp++;
      if (press_count !== 8'd0) begin
         n_bad++;
         $display("FAIL reset_cnt got %0d want 0", press_count);
      end
      n_cmp++;
      if ({but_press, but_release} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_pulse got %b want 00",
                  {but_press, but_release});
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_switch();
      logic [SW_W-1:0] exp;
      sw_raw = 18'h2A5A5;
      for (int i = 1; i <= 9; i++) begin
         tick();
         exp = (i >= 7) ? 18'h2A5A5 : 18'h0;
         n_cmp++;
         if (sw_out !== exp) begin
            n_bad++;
            $display("FAIL sw_latency edge %0d got %h want %h",
                     i, sw_out, exp);
         end
      end
   endtask

   task automatic test_bounce();
      but_raw = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 3) but_raw = 1'b1;
         n_cmp++;
         if ({but_out, but_press, press_count} !== {1'b1, 1'b0, 8'd0}) begin
            n_bad++;
            $display("FAIL bounce edge %0d got out=%b press=%b cnt=%0d want 1 0 0",
                     i, but_out, but_press, press_count);
         end
      end
   endtask

   task automatic test_press();
      logic       e_out;
      logic       e_pls;
      logic [7:0] e_cnt;
      but_raw = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         e_out = (i >= 7) ? 1'b0 : 1'b1;
         e_pls = (i == 7);
         e_cnt = (i >= 7) ? 8'd1 : 8'd0;
         n_cmp++;
         if ({but_out, but_press, but_release, press_count} !==
             {e_out, e_pls, 1'b0, e_cnt}) begin
            n_bad++;
            $display("FAIL press edge %0d got %b%b%b cnt=%0d want %b%b0 cnt=%0d",
                     i, but_out, but_press, but_release, press_count,
                     e_out, e_pls, e_cnt);
         end
      end
      but_raw = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         e_out = (i >= 7) ? 1'b1 : 1'b0;
         e_pls = (i == 7);
         n_cmp++;
         if ({but_out, but_press, but_release, press_count} !==
             {e_out, 1'b0, e_pls, 8'd1}) begin
            n_bad++;
            $display("FAIL release edge %0d got %b%b%b cnt=%0d want %b0%b cnt=1",
                     i, but_out, but_press, but_release, press_count,
                     e_out, e_pls);
         end
      end
   endtask

   task automatic test_midrun_reset();
      but_raw = 1'b0;
      repeat (8) tick();
      sw_raw = 18'h15A5A;
      repeat (4) tick();
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (sw_out !== 18'h0) begin
         n_bad++;
         $display("FAIL midreset_sw got %h want 0", sw_out);
      end
      n_cmp++;
      if (but_out !== 1'b1) begin
         n_bad++;
         $display("FAIL midreset_but got %b want 1", but_out);
      end
      n_cmp++;
      if (press_count !== 8'd0) begin
         n_bad++;
         $display("FAIL midreset_cnt got %0d want 0", press_count);
      end
      n_cmp++;
      if ({but_press, but_release} !== 2'b00) begin
         n_bad++;
         $display("FAIL midreset_pulse got %b want 00",
                  {but_press, but_release});
      end
      sw_raw  = '0;
      but_raw = 1'b1;
      tick();
      reset_n = 1'b1;
      repeat (10) tick();
      n_cmp++;
      if ({sw_out, but_out, press_count} !== {18'h0, 1'b1, 8'd0}) begin
         n_bad++;
         $display("FAIL discard got sw=%h but=%b cnt=%0d want 0 1 0",
                  sw_out, but_out, press_count);
      end
   endtask

   task automatic test_glitch();
      logic [SW_W-1:0] exp;
      for (int j = 0; j < 20; j++) begin
         sw_raw = {17'h0, ((j / 2) % 2) == 0};
         tick();
         n_cmp++;
         if (sw_out !== 18'h0) begin
            n_bad++;
            $display("FAIL glitch cycle %0d got %h want 0", j, sw_out);
         end
      end
      sw_raw = 18'h1;
      for (int i = 1; i <= 10; i++) begin
         tick();
         exp = (i >= 7) ? 18'h1 : 18'h0;
         n_cmp++;
         if (sw_out !== exp) begin
            n_bad++;
            $display("FAIL settle edge %0d got %h want %h", i, sw_out, exp);
         end
      end
   endtask

   task automatic test_wrap();
      int pulses;
      int both;
      pulses = 0;
      both   = 0;
      for (int p = 1; p <= 256; p++) begin
         but_raw = 1'b0;
         repeat (8) begin
            tick();
            if (but_press) pulses++;
            if (but_press && but_release) both++;
         end
         but_raw = 1'b1;
         repeat (8) begin
            tick();
            if (but_press) pulses++;
            if (but_press && but_release) both++;
         end
         if (p == 255) begin
            n_cmp++;
            if (press_count !== 8'd255) begin
               n_bad++;
               $display("FAIL wrap_255 got %0d want 255", press_count);
            end
         end
      end
      n_cmp++;
      if (press_count !== 8'd0) begin
         n_bad++;
         $display("FAIL wrap_cnt got %0d want 0", press_count);
      end
      n_cmp++;
      if (pulses !== 256) begin
         n_bad++;
         $display("FAIL wrap_pulses got %0d want 256", pulses);
      end
      n_cmp++;
      if (both !== 0) begin
         n_bad++;
         $display("FAIL pulse_overlap got %0d want 0", both);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_switch();
      test_bounce();
      test_press();
      test_midrun_reset();
      test_glitch();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
